// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci arbiter slice.
// Holds the sequencer state encoding, the core result width/saturation
// value and the default arbiter parameters.
package fib_pkg;

  localparam int unsigned FIB_W       = 20;
  localparam int unsigned FIB_SAT     = 9999;
  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_NW      = 5;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RESPOND   = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

endpackage

// File: rtl/fib_arbiter_rr_pick.sv
// Round-robin first-set-bit finder.
// Ports:
//   req   - request vector
//   ptr   - highest-priority position for this scan
//   idx   - index of first set bit at or after ptr (wrapping)
//   valid - at least one request is set
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  // Scan ptr, ptr+1, ... modulo NREQ; the first hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin sequencer sharing one Fibonacci core among NREQ requesters.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   req, req_n    - per-requester request level and packed NW-bit indices
//   ack, err      - one-cycle ack to the winner; err marks a core timeout
//   result        - result of last transaction, held until next ack
//   grant, busy   - one-hot current owner; high outside IDLE
//   fib_start/i   - start pulse and zero-extended index to the core
//   fib_ready, fib_done_tick, fib_f - core status and result
module fib_arbiter
  import fib_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned NW      = DEF_NW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NW-1:0]   req_n,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [FIB_W-1:0]     result,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 fib_start,
  output logic [FIB_W-1:0]     fib_i,
  input  logic                 fib_ready,
  input  logic                 fib_done_tick,
  input  logic [FIB_W-1:0]     fib_f
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [NW-1:0]   n_reg;
  logic [TW-1:0]   timer;

  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [NW-1:0]   pick_n;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Index field and one-hot forms of the candidate and the current owner.
  always_comb begin
    pick_n  = '0;
    pick_oh = '0;
    gnt_oh  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == pick_idx) begin
        pick_n     = req_n[k*NW +: NW];
        pick_oh[k] = 1'b1;
      end
      if (IW'(k) == gnt_idx) begin
        gnt_oh[k] = 1'b1;
      end
    end
  end

  assign ptr_next = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

  // n_reg is a register; fib_i is only its zero extension.
  assign fib_i = FIB_W'(n_reg);

  // Sequencer: every output below changes only on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      n_reg     <= '0;
      timer     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      result    <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      fib_start <= 1'b0;
    end else begin
      fib_start <= 1'b0;
      ack       <= '0;
      case (state)
        S_IDLE: begin
          if (fib_ready && pick_valid) begin
            gnt_idx   <= pick_idx;
            n_reg     <= pick_n;
            grant     <= pick_oh;
            busy      <= 1'b1;
            fib_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          timer <= timer + TW'(1);
          // done wins over a simultaneous timeout
          if (fib_done_tick) begin
            result <= fib_f;
            err    <= 1'b0;
            ack    <= gnt_oh;
            state  <= S_RESPOND;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= gnt_oh;
            state  <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          rr_ptr <= ptr_next;
          grant  <= '0;
          state  <= S_DRAIN;
        end
        S_DRAIN: begin
          // core still holding done for its display period
          if (fib_ready) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed bench for fib_arbiter with a behavioural Fibonacci core model.
module tb_fib_arbiter;
  import fib_pkg::*;

  localparam int NREQ    = 4;
  localparam int NW      = 5;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ-1:0]  ack;
  logic             err;
  logic [19:0]      result;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic             fib_start;
  logic [19:0]      fib_i;
  logic             fib_ready;
  logic             fib_done_tick;
  logic [19:0]      fib_f;

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;
  bit hang = 1'b0;

  fib_arbiter #(
    .NREQ    (NREQ),
    .NW      (NW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_n         (req_n),
    .ack           (ack),
    .err           (err),
    .result        (result),
    .grant         (grant),
    .busy          (busy),
    .fib_start     (fib_start),
    .fib_i         (fib_i),
    .fib_ready     (fib_ready),
    .fib_done_tick (fib_done_tick),
    .fib_f         (fib_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] fibsat(input logic [19:0] n);
    int a = 0;
    int b = 1;
    int t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (a > int'(FIB_SAT)) ? 20'(FIB_SAT) : 20'(a);
  endfunction

  // Core model: done rises n+2 cycles after start (2 for n<2), held HOLD cycles.
  int         mst;
  int         mcnt;
  int         mhold;
  logic [19:0] mres;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mst           <= 0;
      mcnt          <= 0;
      mhold         <= 0;
      mres          <= '0;
      fib_ready     <= 1'b1;
      fib_done_tick <= 1'b0;
      fib_f         <= '0;
    end else begin
      case (mst)
        0: if (fib_start) begin
             mst       <= 1;
             fib_ready <= 1'b0;
             mcnt      <= (fib_i < 20'd2) ? 1 : int'(fib_i) + 1;
             mres      <= fibsat(fib_i);
           end
        1: if (mcnt == 1) begin
             if (hang) begin
               mst       <= 0;
               fib_ready <= 1'b1;
             end else begin
               mst           <= 2;
               fib_done_tick <= 1'b1;
               fib_f         <= mres;
               mhold         <= HOLD;
             end
           end else begin
             mcnt <= mcnt - 1;
           end
        default: if (mhold == 1) begin
             mst           <= 0;
             fib_done_tick <= 1'b0;
             fib_ready     <= 1'b1;
           end else begin
             mhold <= mhold - 1;
           end
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_n(input int k, input logic [4:0] v);
    req_n[k*NW +: NW] = v;
  endtask

  // Raise reqm, follow one transaction to its ack and check it.
  task automatic run_txn(input string tag, input logic [3:0] reqm, input int exp_idx,
                         input int exp_res, input bit exp_err, input int exp_lat,
                         input int n_after, input bit drop);
    int         starts = 0;
    int         scyc   = 0;
    bit         got    = 1'b0;
    logic [4:0] exp_n;
    logic [3:0] exp_oh;
    exp_n  = req_n[exp_idx*NW +: NW];
    exp_oh = 4'(1 << exp_idx);
    req    = reqm;
    for (int t = 0; t < 300 && !got; t++) begin
      @(posedge clk); #1;
      if (fib_start) begin
        starts++;
        scyc = cyc;
        check_val({tag, "_fib_i"}, 32'(fib_i), 32'(exp_n));
        if (n_after >= 0) set_n(exp_idx, 5'(n_after));
        if (drop) req = '0;
      end
      if (ack != '0) begin
        got = 1'b1;
        check_val({tag, "_ack"}, 32'(ack), 32'(exp_oh));
        check_val({tag, "_grant"}, 32'(grant), 32'(exp_oh));
        check_val({tag, "_result"}, 32'(result), 32'(exp_res));
        check_val({tag, "_err"}, 32'(err), 32'(exp_err));
        check_val({tag, "_starts"}, 32'(starts), 32'd1);
        if (exp_lat >= 0) check_val({tag, "_latency"}, 32'(cyc - scyc), 32'(exp_lat));
      end
    end
    if (!got) begin
      check_val({tag, "_no_ack"}, 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      check_val({tag, "_ack_width"}, 32'(ack), 32'd0);
      check_val({tag, "_grant_clr"}, 32'(grant), 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ack"}, 32'(ack), 32'd0);
    check_val({tag, "_grant"}, 32'(grant), 32'd0);
    check_val({tag, "_result"}, 32'(result), 32'd0);
    check_val({tag, "_fib_i"}, 32'(fib_i), 32'd0);
    check_val({tag, "_err_busy_start"}, 32'({err, busy, fib_start}), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    req   = '0;
    req_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("post_reset");

    // Round robin from rr_ptr=0 with 1011 held: 0,1,3,0,1
    set_n(0, 5'd2); set_n(1, 5'd3); set_n(2, 5'd5); set_n(3, 5'd4);
    run_txn("rr0", 4'b1011, 0, 1, 1'b0, 5, -1, 1'b0);
    run_txn("rr1", 4'b1011, 1, 2, 1'b0, 6, -1, 1'b0);
    run_txn("rr3", 4'b1011, 3, 3, 1'b0, 7, -1, 1'b0);
    run_txn("rr0b", 4'b1011, 0, 1, 1'b0, 5, -1, 1'b0);
    run_txn("rr1b", 4'b1011, 1, 2, 1'b0, 6, -1, 1'b0);
    req = '0;

    // n=10, with req_n rewritten after grant (ignored)
    set_n(0, 5'd10);
    run_txn("n10", 4'b0001, 0, 55, 1'b0, 13, 30, 1'b0);
    req = '0;

    set_n(1, 5'd20);
    run_txn("n20", 4'b0010, 1, 6765, 1'b0, 23, -1, 1'b0);
    req = '0;
    // saturated result, request withdrawn right after grant
    set_n(1, 5'd25);
    run_txn("n25", 4'b0010, 1, 9999, 1'b0, 28, -1, 1'b1);
    req = '0;

    set_n(0, 5'd0);
    run_txn("n0", 4'b0001, 0, 0, 1'b0, 3, -1, 1'b0);
    req = '0;
    set_n(0, 5'd1);
    run_txn("n1", 4'b0001, 0, 1, 1'b0, 3, -1, 1'b0);
    req = '0;

    // Core never signals done: TIMEOUT cycles in WAIT_DONE, then ack
    hang = 1'b1;
    set_n(2, 5'd7);
    run_txn("tmo", 4'b0100, 2, 0, 1'b1, TIMEOUT + 1, -1, 1'b0);
    req  = '0;
    hang = 1'b0;
    set_n(2, 5'd6);
    run_txn("post_tmo", 4'b0100, 2, 8, 1'b0, 9, -1, 1'b0);
    req = '0;

    // Reset mid WAIT_DONE; rr_ptr is 3 here so requester 3 wins first
    set_n(0, 5'd5); set_n(3, 5'd9);
    req  = 4'b1001;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk); #1;
      seen = fib_start;
    end
    check_val("rst_start_seen", 32'(seen), 32'd1);
    check_val("rst_grant_pre", 32'(grant), 32'b1000);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check_reset_vals("rst_async");
    @(posedge clk); #1;
    check_reset_vals("rst_held");
    reset = 1'b0;
    run_txn("rst_after", 4'b1001, 0, 5, 1'b0, 8, -1, 1'b0);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/fib_arbiter.md
Name: fib_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Fibonacci FSMD core among NREQ requesters. It selects a requester, issues a start with that requester's index n, and waits for the core's done indication. It then returns the 20-bit (9999-saturated) result with a one-cycle ack to the winner. Sits between board-level request sources (switch/button channels) and the single fib core instance.

Parameters:
NREQ, 4, number of requesters (2..8)
NW, 5, width of each requester's index field
TIMEOUT, 64, max cycles in WAIT_DONE before error abort (core needs <=33)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level; held until ack
req_n  in  NREQ*NW  packed indices; requester k uses bits [k*NW +: NW]
ack  out  NREQ  one-cycle pulse to the served requester
err  out  1  valid with ack; 1 = core timed out, result forced 0
result  out  20  result of last transaction; stable until next ack
grant  out  NREQ  one-hot current owner; 0 when idle
busy  out  1  high in any state except IDLE
fib_start  out  1  start pulse to core
fib_i  out  20  index to core, zero-extended from NW
fib_ready  in  1  core ready
fib_done_tick  in  1  core done (high for many cycles)
fib_f  in  20  core result

Behaviour:
- Reset: state IDLE, rr_ptr=0, ack=0, err=0, result=0, grant=0, busy=0, fib_start=0, fib_i=0, timer=0. Reset mid-transaction aborts with no ack issued.
- States: IDLE, ISSUE, WAIT_DONE, RESPOND, DRAIN. All outputs are registered or decoded from registered state only; no combinational path from req to ack.
- IDLE: when fib_ready=1 and |req, pick the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NREQ). Latch gnt_idx and that requester's req_n into n_reg, set grant, go to ISSUE. If fib_ready=0, stay in IDLE.
- ISSUE: fib_start=1 for exactly one cycle, fib_i={0,n_reg}; clear timer; go to WAIT_DONE.
- WAIT_DONE: timer increments each cycle.
  - fib_done_tick=1: result<=fib_f, err<=0, go to RESPOND.
  - Else if timer==TIMEOUT-1: result<=0, err<=1, go to RESPOND.
  - done_tick takes priority if both occur in the same cycle.
- RESPOND: ack[gnt_idx]=1 for one cycle; rr_ptr<=(gnt_idx+1) mod NREQ; grant<=0; go to DRAIN.
- DRAIN: wait for fib_ready=1, then go to IDLE. The core holds done_tick for its display hold period. No new start is issued until the core is ready again.
- Request withdrawn after grant: the transaction still completes and ack still pulses. The requester must ignore an unexpected ack.
- req_n changes after grant are ignored (n_reg already latched).
- Latency from grant to ack: 1 (ISSUE) + core op cycles + 1. For n>=2 this is n+3 cycles after ISSUE; for n=0/1 it is 3.
- Index width: n_reg is NW bits; values >19 are legal and the core saturates the result at 9999.
- Fairness: a requester holding req is served within NREQ transactions.

Decomposition:
- Shared package fib_pkg: state encoding constants, FIB_W=20, FIB_SAT=9999, default NW and TIMEOUT.
- One sub-module, rr_pick: combinational round-robin first-set-bit finder from rr_ptr. Outputs index and valid.
- The fib core stays outside the arbiter; the top level wires them together.

Test Plan:
- req=0001, n0=10 -> fib_start one pulse with fib_i=10; ack=0001 with result=55, err=0.
- req=0010, n1=20 -> result=6765. Then n1=25 -> result=9999 (saturated).
- n=0 -> result=0; n=1 -> result=1; both ack 3 cycles after ISSUE.
- req=1011 held continuously, rr_ptr=0 -> service order 0,1,3,0,1; bit 2 never granted.
- Core model never raises done_tick -> ack after TIMEOUT cycles with err=1, result=0; next request is served normally.
- Reset asserted mid-WAIT_DONE -> all outputs return to reset values next cycle, no ack. Serve rr_ptr=0 first after release.
